// File: rtl/gps_pkg.sv
// Shared constants, state types and helpers for the GPS UART receive path.
package gps_pkg;

  localparam logic [7:0] ASC_DOLLAR = 8'h24;
  localparam logic [7:0] ASC_STAR   = 8'h2A;
  localparam logic [7:0] ASC_COMMA  = 8'h2C;
  localparam logic [7:0] ASC_CR     = 8'h0D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } rx_state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_BODY,
    P_HEX1,
    P_HEX2
  } nmea_phase_t;

  // Clocks per serial bit, rounded to nearest.
  function automatic int bit_clks(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h41) && (c <= 8'h46));
  endfunction

  function automatic logic [3:0] hex_nib(input logic [7:0] c);
    return (c <= 8'h39) ? c[3:0] : 4'(c[3:0] + 4'd9);
  endfunction

endpackage

// File: rtl/nmea_checksum.sv
// NMEA sentence tracker: XOR of the body between '$' and '*', compared
// against the two trailing uppercase hex characters.
module nmea_checksum
  import gps_pkg::*;
(
  input  logic       clock_50mhz,
  input  logic       reset_n,
  input  logic [7:0] rx_byte,
  input  logic       byte_stb,
  input  logic       abort,
  output logic       sentence_done,
  output logic       checksum_ok
);

  nmea_phase_t phase;
  logic [7:0]  xor_acc;
  logic [3:0]  hi_nib;
  logic        bad_hex;

  always_ff @(posedge clock_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      phase         <= P_IDLE;
      xor_acc       <= 8'h00;
      hi_nib        <= 4'h0;
      bad_hex       <= 1'b0;
      sentence_done <= 1'b0;
      checksum_ok   <= 1'b0;
    end else begin
      sentence_done <= 1'b0;
      if (abort) begin
        phase <= P_IDLE;
      end else if (byte_stb) begin
        if (rx_byte == ASC_DOLLAR) begin
          xor_acc <= 8'h00;
          bad_hex <= 1'b0;
          phase   <= P_BODY;
        end else begin
          case (phase)
            P_BODY: begin
              if (rx_byte == ASC_STAR) phase <= P_HEX1;
              else                     xor_acc <= xor_acc ^ rx_byte;
            end
            P_HEX1: begin
              hi_nib  <= hex_nib(rx_byte);
              bad_hex <= !is_hex(rx_byte);
              phase   <= P_HEX2;
            end
            P_HEX2: begin
              sentence_done <= 1'b1;
              checksum_ok   <= !bad_hex && is_hex(rx_byte) &&
                               ({hi_nib, hex_nib(rx_byte)} == xor_acc);
              phase         <= P_IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/gps_uart_rx.sv
// 8N1 receiver for the GPS NMEA stream with a stretched data_valid so the
// downstream 3-FF valid synchroniser always sees each byte with data stable.
module gps_uart_rx
  import gps_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int VALID_HOLD = 8
) (
  input  logic       clock_50mhz,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_error,
  output logic       sentence_done,
  output logic       checksum_ok
);

  localparam int              BIT_CLKS  = bit_clks(CLK_HZ, BAUD);
  localparam int              HALF_CLKS = BIT_CLKS / 2;
  localparam logic [15:0]     BIT_M1    = 16'(BIT_CLKS - 1);
  localparam logic [15:0]     HALF_M1   = 16'(HALF_CLKS - 1);
  localparam int              HW        = $clog2(VALID_HOLD + 1);
  localparam logic [HW-1:0]   HOLD_INIT = HW'(VALID_HOLD);

  if ((VALID_HOLD < 4) || (VALID_HOLD >= 9 * BIT_CLKS)) begin : g_bad_hold
    $error("gps_uart_rx: VALID_HOLD out of range");
  end

  logic [1:0]    rx_sync;
  logic          rx_s;
  rx_state_t     state, state_nxt;
  logic [15:0]   timer, timer_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shift_q, shift_nxt;
  logic          good_stb, ferr;
  logic [HW-1:0] hold_cnt;

  assign rx_s       = rx_sync[1];
  assign data_valid = (hold_cnt != '0);

  always_ff @(posedge clock_50mhz or negedge reset_n) begin
    if (!reset_n) rx_sync <= 2'b11;
    else          rx_sync <= {rx_sync[0], rx};
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer + 16'd1;
    idx_nxt   = idx;
    shift_nxt = shift_q;
    good_stb  = 1'b0;
    ferr      = 1'b0;
    case (state)
      S_IDLE: begin
        timer_nxt = 16'd0;
        if (!rx_s) state_nxt = S_START;
      end
      S_START: begin
        if (timer == HALF_M1) begin
          timer_nxt = 16'd0;
          idx_nxt   = 3'd0;
          state_nxt = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (timer == BIT_M1) begin
          timer_nxt = 16'd0;
          shift_nxt = {rx_s, shift_q[7:1]};
          idx_nxt   = idx + 3'd1;
          if (idx == 3'd7) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (timer == BIT_M1) begin
          timer_nxt = 16'd0;
          // Back to IDLE at mid-stop so a start bit with zero idle is still caught.
          if (rx_s) begin
            good_stb  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            ferr      = 1'b1;
            state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        timer_nxt = 16'd0;
        if (rx_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      timer       <= 16'd0;
      idx         <= 3'd0;
      shift_q     <= 8'h00;
      data        <= 8'h00;
      hold_cnt    <= '0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      idx         <= idx_nxt;
      shift_q     <= shift_nxt;
      frame_error <= ferr;
      if (good_stb) begin
        data     <= shift_q;
        hold_cnt <= HOLD_INIT;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HW'(1);
      end
    end
  end

  nmea_checksum u_nmea (
    .clock_50mhz   (clock_50mhz),
    .reset_n       (reset_n),
    .rx_byte       (shift_q),
    .byte_stb      (good_stb),
    .abort         (ferr),
    .sentence_done (sentence_done),
    .checksum_ok   (checksum_ok)
  );

endmodule
